// File: rtl/glyph_cell_renderer.sv
// Two-stage pixel classifier for one Sudoku board cell: glyph window/ROM lookup,
// frame-counted error blinking and cursor border, all registered with 2-cycle latency.
module glyph_cell_renderer #(
    parameter int CELL_W    = 16,
    parameter int SCALE     = 1,
    parameter int MARGIN    = 3,
    parameter int BLINK_DIV = 30,
    localparam int CW       = $clog2(CELL_W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_valid,
    input  logic [CW-1:0] cell_x,
    input  logic [CW-1:0] cell_y,
    input  logic [3:0]    num,
    input  logic          enable,
    input  logic          fixed,
    input  logic          selected,
    input  logic          error,
    input  logic          frame_tick,
    output logic          out_valid,
    output logic [1:0]    px_class,
    output logic          num_on,
    output logic          blink_phase
);

    localparam int XW = CW + 1;
    localparam int SH = $clog2(SCALE);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [XW-1:0] LO      = XW'(MARGIN);
    localparam logic [XW-1:0] HI      = XW'(MARGIN + 8 * SCALE);
    localparam logic [XW-1:0] EDGE    = XW'(CELL_W - 1);
    localparam logic [BW-1:0] CNT_MAX = BW'(BLINK_DIV - 1);

    // Row 0 occupies bits 63:56; bit 7 of each row byte is the leftmost column.
    function automatic logic [63:0] glyph_rows(input logic [3:0] n);
        case (n)
            4'd1:    return 64'h1828_4808_0808_08FF;
            4'd2:    return 64'h7E81_0106_1820_40FF;
            4'd3:    return 64'h7E81_0101_1E01_817E;
            4'd4:    return 64'h0C14_2444_84FF_0404;
            4'd5:    return 64'hFF80_80FE_0101_817E;
            4'd6:    return 64'h7E81_80FE_8181_817E;
            4'd7:    return 64'hFF81_0304_0808_0808;
            4'd8:    return 64'h7E81_817E_8181_817E;
            4'd9:    return 64'h7E81_8181_7F01_817E;
            default: return '0;
        endcase
    endfunction

    // Blink counter
    logic [BW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_tick) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Stage 1 combinational decode
    logic [XW-1:0] x_w, y_w;
    logic          in_glyph_d, border_d;
    logic [2:0]    col_d, row_d;

    always_comb begin
        x_w        = {1'b0, cell_x};
        y_w        = {1'b0, cell_y};
        in_glyph_d = (x_w >= LO) && (x_w < HI) && (y_w >= LO) && (y_w < HI);
        col_d      = 3'((x_w - LO) >> SH);
        row_d      = 3'((y_w - LO) >> SH);
        border_d   = (x_w == '0) || (x_w == EDGE) || (y_w == '0) || (y_w == EDGE);
    end

    // Stage 1 registers
    logic       v1_q, in_glyph1_q, border1_q, phase1_q;
    logic [2:0] col1_q, row1_q;
    logic [3:0] num1_q;
    logic       en1_q, fixed1_q, sel1_q, err1_q;

    // Stage 2 combinational
    logic [63:0] rows_w;
    logic [7:0]  row_bits;
    logic        rom_bit, num_on_d;
    logic [1:0]  px_class_d;

    always_comb begin
        rows_w     = glyph_rows(num1_q);
        row_bits   = rows_w[{~row1_q, 3'b000} +: 8];
        rom_bit    = row_bits[~col1_q];
        num_on_d   = en1_q && in_glyph1_q && rom_bit && !(err1_q && phase1_q);
        px_class_d = 2'd0;
        if (!en1_q)
            px_class_d = 2'd0;
        else if (sel1_q && border1_q)
            px_class_d = 2'd3;
        else if (num_on_d)
            px_class_d = fixed1_q ? 2'd1 : 2'd2;
    end

    logic       out_valid_q, num_on_q;
    logic [1:0] px_class_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            v1_q        <= 1'b0;
            in_glyph1_q <= 1'b0;
            border1_q   <= 1'b0;
            phase1_q    <= 1'b0;
            col1_q      <= '0;
            row1_q      <= '0;
            num1_q      <= '0;
            en1_q       <= 1'b0;
            fixed1_q    <= 1'b0;
            sel1_q      <= 1'b0;
            err1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            px_class_q  <= '0;
            num_on_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            v1_q        <= pix_valid;
            in_glyph1_q <= in_glyph_d;
            border1_q   <= border_d;
            phase1_q    <= phase_q;
            col1_q      <= col_d;
            row1_q      <= row_d;
            num1_q      <= num;
            en1_q       <= enable;
            fixed1_q    <= fixed;
            sel1_q      <= selected;
            err1_q      <= error;
            out_valid_q <= v1_q;
            px_class_q  <= px_class_d;
            num_on_q    <= num_on_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign px_class    = px_class_q;
    assign num_on      = num_on_q;
    assign blink_phase = phase_q;

endmodule

// File: tb/tb_glyph_cell_renderer.sv
// Scoreboard bench: two renderer instances (default geometry and a 24px/scale-2 cell)
// driven with directed and random pixels, checked against an arithmetic model.
module tb_glyph_cell_renderer;

    typedef struct {
        int cls;
        int on;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_valid, frame_tick;
    logic [3:0] num;
    logic       enable, fixed, selected, error;
    logic [3:0] xa, ya;
    logic [4:0] xb, yb;
    logic       ova, nona, bpa, ovb, nonb, bpb;
    logic [1:0] pca, pcb;

    exp_t qa[$];
    exp_t qb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ticks = 0;
    int   cyc = 0;

    byte unsigned glyph [10][8] = '{
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h18, 8'h28, 8'h48, 8'h08, 8'h08, 8'h08, 8'h08, 8'hFF},
        '{8'h7E, 8'h81, 8'h01, 8'h06, 8'h18, 8'h20, 8'h40, 8'hFF},
        '{8'h7E, 8'h81, 8'h01, 8'h01, 8'h1E, 8'h01, 8'h81, 8'h7E},
        '{8'h0C, 8'h14, 8'h24, 8'h44, 8'h84, 8'hFF, 8'h04, 8'h04},
        '{8'hFF, 8'h80, 8'h80, 8'hFE, 8'h01, 8'h01, 8'h81, 8'h7E},
        '{8'h7E, 8'h81, 8'h80, 8'hFE, 8'h81, 8'h81, 8'h81, 8'h7E},
        '{8'hFF, 8'h81, 8'h03, 8'h04, 8'h08, 8'h08, 8'h08, 8'h08},
        '{8'h7E, 8'h81, 8'h81, 8'h7E, 8'h81, 8'h81, 8'h81, 8'h7E},
        '{8'h7E, 8'h81, 8'h81, 8'h81, 8'h7F, 8'h01, 8'h81, 8'h7E}
    };

    glyph_cell_renderer u_a (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .cell_x(xa), .cell_y(ya),
        .num(num), .enable(enable), .fixed(fixed), .selected(selected), .error(error),
        .frame_tick(frame_tick), .out_valid(ova), .px_class(pca), .num_on(nona),
        .blink_phase(bpa)
    );

    glyph_cell_renderer #(.CELL_W(24), .SCALE(2), .MARGIN(4), .BLINK_DIV(3)) u_b (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .cell_x(xb), .cell_y(yb),
        .num(num), .enable(enable), .fixed(fixed), .selected(selected), .error(error),
        .frame_tick(frame_tick), .out_valid(ovb), .px_class(pcb), .num_on(nonb),
        .blink_phase(bpb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic int phase_of(input int which);
        return which == 0 ? (ticks / 30) % 2 : (ticks / 3) % 2;
    endfunction

    function automatic void model(input int x, input int y, input int n, input int en,
                                  input int fx, input int sel, input int er, input int ph,
                                  input int cw, input int sc, input int m,
                                  output int cls, output int on);
        int inw, b, brd;
        inw = (x >= m) && (x < m + 8 * sc) && (y >= m) && (y < m + 8 * sc);
        b = 0;
        if (inw && n >= 1 && n <= 9)
            b = (glyph[n][(y - m) / sc] >> (7 - (x - m) / sc)) & 1;
        on  = (en && b && !(er && ph)) ? 1 : 0;
        brd = (x == 0) || (y == 0) || (x == cw - 1) || (y == cw - 1);
        if (!en)            cls = 0;
        else if (sel && brd) cls = 3;
        else if (on)        cls = fx ? 1 : 2;
        else                cls = 0;
    endfunction

    task automatic drive(input logic v, input int xa_, input int ya_, input int xb_,
                         input int yb_, input int n, input logic en, input logic fx,
                         input logic sel, input logic er, input logic tk);
        exp_t e;
        int c, o;
        @(negedge clk);
        pix_valid = v; xa = 4'(xa_); ya = 4'(ya_); xb = 5'(xb_); yb = 5'(yb_);
        num = 4'(n); enable = en; fixed = fx; selected = sel; error = er; frame_tick = tk;
        if (v) begin
            model(xa_, ya_, n, en, fx, sel, er, phase_of(0), 16, 1, 3, c, o);
            e.cls = c; e.on = o; e.cyc = cyc; qa.push_back(e);
            model(xb_, yb_, n, en, fx, sel, er, phase_of(1), 24, 2, 4, c, o);
            e.cls = c; e.on = o; e.cyc = cyc; qb.push_back(e);
        end
        if (tk) ticks++;
    endtask

    task automatic mon(input int which, input logic ov, input logic [1:0] pc,
                       input logic no, input logic bp);
        exp_t e;
        int ph, has;
        ph = phase_of(which);
        vectors++;
        if (int'(bp) != ph) begin
            miscompares++;
            $display("FAIL blink_phase dut%0d cyc %0d: got %0d expected %0d", which, cyc, bp, ph);
        end
        has = (which == 0) ? qa.size() : qb.size();
        if (ov) begin
            vectors++;
            if (has == 0) begin
                miscompares++;
                $display("FAIL spurious_out dut%0d cyc %0d: got out_valid=1 expected 0", which, cyc);
            end else begin
                e = (which == 0) ? qa.pop_front() : qb.pop_front();
                if (int'(pc) != e.cls || int'(no) != e.on || cyc != e.cyc + 2) begin
                    miscompares++;
                    $display("FAIL pixel dut%0d cyc %0d: got class=%0d num_on=%0d expected class=%0d num_on=%0d issued_cyc=%0d",
                             which, cyc, pc, no, e.cls, e.on, e.cyc);
                end
            end
        end else if (has != 0) begin
            e = (which == 0) ? qa[0] : qb[0];
            if (cyc >= e.cyc + 2) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_out dut%0d cyc %0d: got out_valid=0 expected 1 (issued %0d)", which, cyc, e.cyc);
                if (which == 0) void'(qa.pop_front()); else void'(qb.pop_front());
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            mon(0, ova, pca, nona, bpa);
            mon(1, ovb, pcb, nonb, bpb);
        end
    end

    task automatic check_reset_state();
        vectors++;
        if ({ova, pca, nona, bpa, ovb, pcb, nonb, bpb} != 10'b0) begin
            miscompares++;
            $display("FAIL reset_state: got a=%b%b%b%b b=%b%b%b%b expected all 0",
                     ova, pca, nona, bpa, ovb, pcb, nonb, bpb);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; pix_valid = 1'b0; frame_tick = 1'b0; num = '0;
        enable = 1'b0; fixed = 1'b0; selected = 1'b0; error = 1'b0;
        xa = '0; ya = '0; xb = '0; yb = '0;
        #1;
        check_reset_state();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic glyph hit / miss, and the scaled-window cell
        drive(1, 6, 3, 4, 4, 1, 1, 1, 0, 0, 0);
        drive(1, 5, 3, 5, 5, 1, 1, 1, 0, 0, 0);
        drive(1, 6, 3, 4, 4, 7, 1, 1, 0, 0, 0);
        drive(1, 6, 3, 5, 5, 7, 1, 1, 0, 0, 0);
        drive(1, 6, 3, 20, 4, 7, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back raster of digit 8 as a user digit
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                drive(1, x, y, x + 4, y + 4, 8, 1, 0, 0, 0, 0);

        // Error blinking across 70 frame ticks
        for (int i = 0; i < 70; i++)
            drive(1, 3, 3, 4, 4, 5, 1, 1, 0, 1, 1);

        // Cursor border with error and blink; then disabled cell
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 7, 0, 7, 1, 1, 1, 1, 1, 0);
            drive(1, 15, 15, 23, 23, 1, 1, 1, 1, 1, 0);
            drive(1, 0, 7, 0, 7, 1, 0, 1, 1, 1, 0);
            drive(1, 15, 15, 23, 23, 1, 0, 1, 1, 1, 0);
            drive(1, 3, 3, 4, 4, 5, 1, 0, 1, 1, 1);
        end

        // Randomized traffic
        for (int i = 0; i < 2000; i++)
            drive(($urandom_range(3) != 0), $urandom_range(15), $urandom_range(15),
                  $urandom_range(23), $urandom_range(23), $urandom_range(15),
                  ($urandom_range(7) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(3) == 0));

        // Asynchronous reset with pixels in flight
        drive(1, 6, 3, 6, 4, 1, 1, 1, 0, 0, 1);
        drive(1, 6, 3, 6, 4, 1, 1, 1, 0, 0, 1);
        drive(1, 6, 3, 6, 4, 1, 1, 1, 0, 0, 1);
        #2;
        reset = 1'b1;
        pix_valid = 1'b0;
        frame_tick = 1'b0;
        qa.delete();
        qb.delete();
        ticks = 0;
        #1;
        check_reset_state();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 6, 3, 6, 4, 1, 1, 1, 0, 0, 0);
        repeat (5) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vectors++;
        if (qa.size() != 0 || qb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
